// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED serial-bus receive path.
package oled_pkg;
  localparam int unsigned OLED_BYTE_W     = 8;
  localparam int unsigned OLED_FIFO_DEPTH = 16;
  localparam logic        DC_CMD          = 1'b0;
  localparam logic        DC_DATA         = 1'b1;

  typedef struct packed {
    logic                   dc;
    logic [OLED_BYTE_W-1:0] data;
  } oled_entry_t;
endpackage

// File: rtl/oled_rx_fifo.sv
// First-word-fall-through queue of decoded bytes with a registered head and valid.
module oled_rx_fifo
  import oled_pkg::*;
#(
  parameter int unsigned DEPTH = OLED_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        push,
  input  oled_entry_t din,
  input  logic        pop,
  output logic        full_c,
  output logic        valid,
  output oled_entry_t dout
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  oled_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [CW-1:0] count, count_n;
  logic          wr_en, rd_en;
  oled_entry_t   head_n;

  // Next pointers and the entry that will sit at the head after this edge.
  always_comb begin
    full_c   = (count == CW'(DEPTH));
    rd_en    = pop & valid;
    wr_en    = push & (~full_c | rd_en);
    wr_ptr_n = wr_ptr + AW'(wr_en);
    rd_ptr_n = rd_ptr + AW'(rd_en);
    count_n  = count + CW'(wr_en) - CW'(rd_en);
    head_n   = '0;
    if (count_n != '0) begin
      if (wr_en && (wr_ptr == rd_ptr_n)) head_n = din;
      else                               head_n = mem[rd_ptr_n];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      dout   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      dout   <= '0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      valid  <= (count_n != '0);
      dout   <= head_n;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/oled_spi_rx.sv
// Oversampling receiver for the 4-wire OLED bus: syncs pins, assembles MSB-first bytes, queues them.
module oled_spi_rx
  import oled_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = OLED_FIFO_DEPTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        CLK_100MHz,
  input  logic        RST_N,
  input  logic        OLED_CLK,
  input  logic        OLED_DIN,
  input  logic        OLED_CS,
  input  logic        OLED_D_C,
  input  logic        OLED_RES,
  output logic [7:0]  rx_byte,
  output logic        rx_dc,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        frame_err,
  output logic        overflow,
  output logic        in_reset,
  output logic [15:0] byte_count
);
  localparam int unsigned CNT_W = $clog2(OLED_BYTE_W);

  logic [SYNC_STAGES-1:0] sclk_sync, din_sync, cs_sync, dc_sync, res_sync;
  logic [SYNC_STAGES:0]   warm;
  logic                   sclk_s, din_s, cs_s, dc_s, res_s;
  logic                   sclk_prev, cs_prev, armed;
  logic                   sync_ok, sclk_rise, cs_fall, cs_rise, bit_take;
  logic [CNT_W-1:0]       bit_cnt;
  logic [OLED_BYTE_W-2:0] shift_q;
  logic                   push_pend, push_ok, push_drop, pop, full_c;
  oled_entry_t            push_entry, head;

  // Pin synchronisers; idle levels on reset so no false edges appear.
  always_ff @(posedge CLK_100MHz or negedge RST_N) begin
    if (!RST_N) begin
      sclk_sync <= '1;
      cs_sync   <= '1;
      res_sync  <= '1;
      din_sync  <= '0;
      dc_sync   <= {SYNC_STAGES{DC_CMD}};
      warm      <= '0;
      sclk_prev <= 1'b1;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], OLED_CLK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], OLED_CS};
      res_sync  <= {res_sync[SYNC_STAGES-2:0], OLED_RES};
      din_sync  <= {din_sync[SYNC_STAGES-2:0], OLED_DIN};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], OLED_D_C};
      warm      <= {warm[SYNC_STAGES-1:0], 1'b1};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  // Edges are trusted only once the sync chain and its history hold real pin samples.
  always_comb begin
    sclk_s    = sclk_sync[SYNC_STAGES-1];
    cs_s      = cs_sync[SYNC_STAGES-1];
    res_s     = res_sync[SYNC_STAGES-1];
    din_s     = din_sync[SYNC_STAGES-1];
    dc_s      = dc_sync[SYNC_STAGES-1];
    sync_ok   = warm[SYNC_STAGES];
    sclk_rise = sync_ok & sclk_s & ~sclk_prev;
    cs_fall   = sync_ok & ~cs_s & cs_prev;
    cs_rise   = sync_ok & cs_s & ~cs_prev;
    bit_take  = sclk_rise & ~cs_s & res_s & armed;
    pop       = rx_ready & rx_valid;
    push_ok   = push_pend & res_s & (~full_c | pop);
    push_drop = push_pend & res_s & full_c & ~pop;
  end

  // Bit assembly; armed keeps bits from before the first clean CS# fall out of any byte.
  always_ff @(posedge CLK_100MHz or negedge RST_N) begin
    if (!RST_N) begin
      armed      <= 1'b0;
      bit_cnt    <= '0;
      shift_q    <= '0;
      push_pend  <= 1'b0;
      push_entry <= '0;
      frame_err  <= 1'b0;
    end else begin
      push_pend <= 1'b0;
      frame_err <= 1'b0;
      if (!res_s) begin
        bit_cnt <= '0;
      end else if (cs_fall) begin
        bit_cnt <= '0;
        armed   <= 1'b1;
      end else if (cs_rise) begin
        frame_err <= (bit_cnt != '0);
        bit_cnt   <= '0;
      end else if (bit_take) begin
        shift_q <= {shift_q[OLED_BYTE_W-3:0], din_s};
        if (bit_cnt == CNT_W'(OLED_BYTE_W - 1)) begin
          push_pend       <= 1'b1;
          push_entry.dc   <= dc_s;
          push_entry.data <= {shift_q, din_s};
          bit_cnt         <= '0;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK_100MHz or negedge RST_N) begin
    if (!RST_N) begin
      overflow   <= 1'b0;
      in_reset   <= 1'b0;
      byte_count <= '0;
    end else begin
      overflow <= push_drop;
      in_reset <= ~res_s;
      if (push_ok) byte_count <= byte_count + 16'(1);
    end
  end

  oled_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (CLK_100MHz),
    .rst_n  (RST_N),
    .flush  (~res_s),
    .push   (push_pend & res_s),
    .din    (push_entry),
    .pop    (pop),
    .full_c (full_c),
    .valid  (rx_valid),
    .dout   (head)
  );

  assign rx_byte = head.data;
  assign rx_dc   = head.dc;
endmodule

// File: tb/tb_oled_spi_rx.sv
// Directed bench for oled_spi_rx: bit-banged bus transfers against hand-computed results.
module tb_oled_spi_rx;
  import oled_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        oled_clk = 1'b1, oled_din = 1'b0, oled_cs = 1'b1, oled_d_c = 1'b0, oled_res = 1'b1;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_byte;
  logic        rx_dc, rx_valid, frame_err, overflow, in_reset;
  logic [15:0] byte_count;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int fe0, ov0;

  always #5 clk = ~clk;

  oled_spi_rx dut (
    .CLK_100MHz (clk),
    .RST_N      (rst_n),
    .OLED_CLK   (oled_clk),
    .OLED_DIN   (oled_din),
    .OLED_CS    (oled_cs),
    .OLED_D_C   (oled_d_c),
    .OLED_RES   (oled_res),
    .rx_byte    (rx_byte),
    .rx_dc      (rx_dc),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .in_reset   (in_reset),
    .byte_count (byte_count)
  );

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overflow)  ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // mode 0: plain; 1: check rx_valid latency on last bit; 2: pop in the same cycle as the push.
  task automatic send_bits(input logic [7:0] b, input int nbits, input logic dc, input int mode);
    for (int i = 0; i < nbits; i++) begin
      oled_clk = 1'b0;
      oled_din = b[7-i];
      oled_d_c = dc;
      ticks(5);
      oled_clk = 1'b1;
      if (i == 7 && mode == 1) begin
        ticks(3);
        check("latency_pre", 32'(rx_valid), 32'd0);
        ticks(1);
        check("latency_post", 32'(rx_valid), 32'd1);
        ticks(1);
      end else if (i == 7 && mode == 2) begin
        ticks(3);
        rx_ready = 1'b1;
        ticks(1);
        rx_ready = 1'b0;
        ticks(1);
      end else begin
        ticks(5);
      end
    end
  endtask

  task automatic pop_check(input string tag, input logic [7:0] b, input logic dc);
    check({tag, "_valid"}, 32'(rx_valid), 32'd1);
    check({tag, "_byte"}, 32'(rx_byte), 32'(b));
    check({tag, "_dc"}, 32'(rx_dc), 32'(dc));
    rx_ready = 1'b1;
    ticks(1);
    rx_ready = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n    = 1'b0;
    oled_clk = 1'b1;
    oled_cs  = 1'b1;
    oled_res = 1'b1;
    rx_ready = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    ticks(6);
    oled_cs = 1'b0;
    ticks(6);
  endtask

  initial begin
    // Reset with the bus toggling
    for (int i = 0; i < 12; i++) begin
      oled_clk = i[0];
      oled_din = i[1];
      oled_cs  = i[2];
      oled_d_c = i[0];
      oled_res = i[3];
      ticks(1);
    end
    check("rst_byte", 32'(rx_byte), 32'd0);
    check("rst_dc", 32'(rx_dc), 32'd0);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_inrst", 32'(in_reset), 32'd0);
    check("rst_count", 32'(byte_count), 32'd0);
    oled_clk = 1'b1; oled_cs = 1'b1; oled_res = 1'b1; oled_din = 1'b0; oled_d_c = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    ticks(10);
    check("idle_valid", 32'(rx_valid), 32'd0);
    check("idle_count", 32'(byte_count), 32'd0);

    // Single command byte with latency check
    oled_cs = 1'b0;
    ticks(6);
    send_bits(8'hAE, 8, DC_CMD, 1);
    check("t2_count", 32'(byte_count), 32'd1);
    pop_check("t2", 8'hAE, DC_CMD);

    // Back-to-back bytes with D/C# tags
    reset_dut();
    send_bits(8'h55, 8, DC_DATA, 0);
    send_bits(8'hAA, 8, DC_DATA, 0);
    send_bits(8'hFF, 8, DC_DATA, 0);
    send_bits(8'h21, 8, DC_CMD, 0);
    check("t3_count", 32'(byte_count), 32'd4);
    pop_check("t3_0", 8'h55, DC_DATA);
    pop_check("t3_1", 8'hAA, DC_DATA);
    pop_check("t3_2", 8'hFF, DC_DATA);
    pop_check("t3_3", 8'h21, DC_CMD);
    check("t3_empty", 32'(rx_valid), 32'd0);

    // CS# rises mid-byte
    fe0 = fe_cnt;
    send_bits(8'hF0, 5, DC_CMD, 0);
    oled_cs = 1'b1;
    ticks(10);
    check("t4_ferr", 32'(fe_cnt - fe0), 32'd1);
    check("t4_novalid", 32'(rx_valid), 32'd0);
    check("t4_count", 32'(byte_count), 32'd4);
    oled_cs = 1'b0;
    ticks(6);
    send_bits(8'h3C, 8, DC_CMD, 0);
    pop_check("t4", 8'h3C, DC_CMD);

    // Fill to overflow, then simultaneous push/pop while full
    reset_dut();
    ov0 = ov_cnt;
    for (int i = 0; i < 17; i++) send_bits(8'(i), 8, DC_DATA, 0);
    ticks(2);
    check("t5_ovf", 32'(ov_cnt - ov0), 32'd1);
    check("t5_count", 32'(byte_count), 32'd16);
    check("t5_head", 32'(rx_byte), 32'd0);
    send_bits(8'h11, 8, DC_DATA, 2);
    ticks(2);
    check("t5_pp_count", 32'(byte_count), 32'd17);
    check("t5_pp_ovf", 32'(ov_cnt - ov0), 32'd1);
    for (int i = 1; i < 16; i++) pop_check("t5_drain", 8'(i), DC_DATA);
    pop_check("t5_last", 8'h11, DC_DATA);
    check("t5_empty", 32'(rx_valid), 32'd0);

    // Display reset mid-byte
    for (int i = 0; i < 4; i++) send_bits(8'hA0 + 8'(i), 8, DC_DATA, 0);
    check("t6_queued", 32'(rx_valid), 32'd1);
    fe0 = fe_cnt;
    send_bits(8'hC0, 3, DC_DATA, 0);
    oled_res = 1'b0;
    ticks(4);
    for (int i = 0; i < 4; i++) begin
      oled_clk = ~oled_clk;
      ticks(5);
    end
    check("t6_inrst", 32'(in_reset), 32'd1);
    check("t6_flushed", 32'(rx_valid), 32'd0);
    oled_clk = 1'b1;
    oled_res = 1'b1;
    ticks(6);
    check("t6_inrst_off", 32'(in_reset), 32'd0);
    check("t6_noferr", 32'(fe_cnt - fe0), 32'd0);
    send_bits(8'h81, 8, DC_DATA, 0);
    pop_check("t6", 8'h81, DC_DATA);
    check("t6_empty", 32'(rx_valid), 32'd0);
    check("t6_count", 32'(byte_count), 32'd22);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
